// File: rtl/rf_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_sb_pkg
// Description : Shared types, constants and helpers for the integer
//               register-file scoreboard (rf_scoreboard / rf_sb_fifo).
// Revision    : 1.0 - initial release
// ============================================================================
package rf_sb_pkg;

  // Default number of in-flight instructions tracked
  localparam int SB_DEPTH_DEF = 4;

  // Architectural integer registers
  localparam int NREGS = 32;

  // One in-flight instruction: does it write rd, and which rd
  typedef struct packed {
    logic       we;
    logic [4:0] rd;
  } sb_entry_t;

  // One-hot decode of a register index; x0 is hard-wired zero and never
  // produces a set bit.
  function automatic logic [NREGS-1:0] onehot_rd(input logic [4:0] rd);
    logic [NREGS-1:0] oh;
    oh = '0;
    if (rd != 5'd0) begin
      oh[rd] = 1'b1;
    end
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_sb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rf_sb_fifo
// Description : Circular in-order FIFO of scoreboard entries. Enqueues issued
//               instructions at the tail, retires from the head, and trims the
//               youngest entries on flush so that only the oldest
//               flush_keep_i survivors remain. Exposes the raw storage plus a
//               per-slot valid vector.
//               Optional macro RF_SB_WB_BYPASS_EN: the stall-valid vector
//               drops the head slot in the cycle it retires.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_sb_fifo
  import rf_sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_req_i,
  input  sb_entry_t             push_data_i,
  input  logic                  pop_req_i,
  input  logic                  flush_i,
  input  logic [CNT_W-1:0]      flush_keep_i,
  output logic                  rdy_o,
  output logic [CNT_W-1:0]      count_o,
  output sb_entry_t [DEPTH-1:0] entries_o,
  output logic [DEPTH-1:0]      valid_o,
  output logic [DEPTH-1:0]      stall_valid_o,
  output logic                  underflow_o
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  C_DEPTH = CNT_W'(DEPTH);

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  sb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic                  err_q, err_d;

  logic                  w_push;
  logic                  w_pop;
  logic [CNT_W-1:0]      w_keep;
  logic [CNT_W-1:0]      w_cnt_ret;

  // Readiness depends only on registered occupancy, never on a same-cycle
  // retire, so a full FIFO refuses an issue even while its head retires.
  assign rdy_o       = (count_q < C_DEPTH);
  assign count_o     = count_q;
  assign entries_o   = mem_q;
  assign underflow_o = err_q;

  // Next-state: retire first, then either flush-trim or enqueue.
  always_comb begin
    w_push    = push_req_i && (count_q < C_DEPTH) && !flush_i;
    w_pop     = pop_req_i && (count_q != '0);
    w_keep    = (flush_keep_i > C_DEPTH) ? C_DEPTH : flush_keep_i;
    w_cnt_ret = count_q - CNT_W'(w_pop);

    head_d    = head_q + PTR_W'(w_pop);
    tail_d    = tail_q;
    count_d   = w_cnt_ret;
    mem_d     = mem_q;
    err_d     = err_q | (pop_req_i && (count_q == '0));

    if (flush_i) begin
      // Keep the oldest survivors; the tail is rebuilt from the new head.
      count_d = (w_cnt_ret < w_keep) ? w_cnt_ret : w_keep;
      tail_d  = head_d + count_d[PTR_W-1:0];
    end else begin
      if (w_push) begin
        mem_d[tail_q] = push_data_i;
      end
      count_d = w_cnt_ret + CNT_W'(w_push);
      tail_d  = tail_q + PTR_W'(w_push);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      mem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
      err_q   <= err_d;
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    logic [PTR_W-1:0] w_off;
    assign w_off       = PTR_W'(gi) - head_q;
    assign valid_o[gi] = (CNT_W'(w_off) < count_q);
`ifdef RF_SB_WB_BYPASS_EN
    // The retiring head no longer blocks readers in its WB cycle.
    assign stall_valid_o[gi] = valid_o[gi] && !(w_pop && (PTR_W'(gi) == head_q));
`else
    assign stall_valid_o[gi] = valid_o[gi];
`endif
  end

endmodule
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : In-order RAW scoreboard beside the ID stage and the int_rf
//               write port. Tracks destination registers of in-flight
//               instructions, publishes a pending-write bitmap and stalls ID
//               while a used source register still has a write outstanding.
//               Optional macro RF_SB_WB_BYPASS_EN: a register whose only
//               pending writer is retiring this cycle does not stall ID.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard #(
  parameter int DEPTH = rf_sb_pkg::SB_DEPTH_DEF,
  parameter int NREGS = rf_sb_pkg::NREGS,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid_i,
  input  logic             issue_we_i,
  input  logic [4:0]       issue_rd_i,
  output logic             issue_rdy_o,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic             rs1_use_i,
  input  logic             rs2_use_i,
  output logic             hazard_stall_o,
  input  logic             wb_valid_i,
  input  logic             flush_i,
  input  logic [CNT_W-1:0] flush_keep_i,
  output logic [NREGS-1:0] pending_o,
  output logic [CNT_W-1:0] inflight_cnt_o,
  output logic             err_underflow_o
);

  import rf_sb_pkg::*;

  sb_entry_t             w_issue_entry;
  sb_entry_t [DEPTH-1:0] w_entries;
  logic [DEPTH-1:0]      w_valid;
  logic [DEPTH-1:0]      w_stall_valid;
  logic [NREGS-1:0]      w_stall_pend;
  logic                  w_rs1_hit;
  logic                  w_rs2_hit;

  // Writes to x0 are recorded as non-writing so x0 never becomes pending.
  always_comb begin
    w_issue_entry.we = issue_we_i && (issue_rd_i != 5'd0);
    w_issue_entry.rd = issue_rd_i;
  end

  rf_sb_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_req_i    (issue_valid_i),
    .push_data_i   (w_issue_entry),
    .pop_req_i     (wb_valid_i),
    .flush_i       (flush_i),
    .flush_keep_i  (flush_keep_i),
    .rdy_o         (issue_rdy_o),
    .count_o       (inflight_cnt_o),
    .entries_o     (w_entries),
    .valid_o       (w_valid),
    .stall_valid_o (w_stall_valid),
    .underflow_o   (err_underflow_o)
  );

  // OR the one-hot rd of every live writing entry; duplicates of one rd keep
  // the bit set until the last of them retires.
  always_comb begin : b_pending
    logic [rf_sb_pkg::NREGS-1:0] oh;
    pending_o    = '0;
    w_stall_pend = '0;
    oh           = '0;
    for (int i = 0; i < DEPTH; i++) begin
      oh = onehot_rd(w_entries[i].rd);
      if (w_valid[i] && w_entries[i].we) begin
        pending_o = pending_o | oh[NREGS-1:0];
      end
      if (w_stall_valid[i] && w_entries[i].we) begin
        w_stall_pend = w_stall_pend | oh[NREGS-1:0];
      end
    end
    pending_o[0]    = 1'b0;
    w_stall_pend[0] = 1'b0;
  end

  // RAW hazard on either used, non-x0 source register.
  always_comb begin
    w_rs1_hit      = rs1_use_i && (rs1_i != 5'd0) && w_stall_pend[rs1_i];
    w_rs2_hit      = rs2_use_i && (rs2_i != 5'd0) && w_stall_pend[rs2_i];
    hazard_stall_o = w_rs1_hit || w_rs2_hit;
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_scoreboard
// Description : Self-checking bench for rf_scoreboard. A driver applies
//               directed then random stimulus, computes the expected outputs
//               from a queue-based reference model and pushes them into an
//               expectation queue; a monitor pops and compares on each
//               falling clock edge. Honours RF_SB_WB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_scoreboard;

  localparam int DEPTH = 4;
  localparam int NREGS = 32;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             issue_valid_i;
  logic             issue_we_i;
  logic [4:0]       issue_rd_i;
  logic             issue_rdy_o;
  logic [4:0]       rs1_i;
  logic [4:0]       rs2_i;
  logic             rs1_use_i;
  logic             rs2_use_i;
  logic             hazard_stall_o;
  logic             wb_valid_i;
  logic             flush_i;
  logic [CNT_W-1:0] flush_keep_i;
  logic [NREGS-1:0] pending_o;
  logic [CNT_W-1:0] inflight_cnt_o;
  logic             err_underflow_o;

  always #5 clk = ~clk;

  rf_scoreboard #(
    .DEPTH (DEPTH),
    .NREGS (NREGS),
    .CNT_W (CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .issue_valid_i   (issue_valid_i),
    .issue_we_i      (issue_we_i),
    .issue_rd_i      (issue_rd_i),
    .issue_rdy_o     (issue_rdy_o),
    .rs1_i           (rs1_i),
    .rs2_i           (rs2_i),
    .rs1_use_i       (rs1_use_i),
    .rs2_use_i       (rs2_use_i),
    .hazard_stall_o  (hazard_stall_o),
    .wb_valid_i      (wb_valid_i),
    .flush_i         (flush_i),
    .flush_keep_i    (flush_keep_i),
    .pending_o       (pending_o),
    .inflight_cnt_o  (inflight_cnt_o),
    .err_underflow_o (err_underflow_o)
  );

  typedef struct {
    logic [31:0]      pend;
    logic [CNT_W-1:0] cnt;
    logic             rdy;
    logic             stall;
    logic             err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned m_rd[$];
  bit          m_we[$];
  bit          m_err;
  bit          in_rst;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Registers with an outstanding write, optionally ignoring one queue slot.
  function automatic logic [31:0] model_pending(input int skip);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < m_rd.size(); i++) begin
      if (i != skip && m_we[i] && m_rd[i] != 0) p[m_rd[i]] = 1'b1;
    end
    return p;
  endfunction

  // Drive one cycle of inputs, record expectations, advance the model.
  task automatic step(input bit iv, input bit we, input int rd,
                      input int r1, input bit u1, input int r2, input bit u2,
                      input bit wb, input bit fl, input int keep);
    exp_t        e;
    int          skip;
    int          k;
    bit          do_push;
    logic [31:0] sp;
    issue_valid_i = iv;
    issue_we_i    = we;
    issue_rd_i    = 5'(rd);
    rs1_i         = 5'(r1);
    rs1_use_i     = u1;
    rs2_i         = 5'(r2);
    rs2_use_i     = u2;
    wb_valid_i    = wb;
    flush_i       = fl;
    flush_keep_i  = CNT_W'(keep);

    e.pend = model_pending(-1);
    e.cnt  = CNT_W'(m_rd.size());
    e.rdy  = (m_rd.size() < DEPTH);
    e.err  = m_err;
    skip   = -1;
`ifdef RF_SB_WB_BYPASS_EN
    if (wb && m_rd.size() > 0) skip = 0;
`endif
    sp      = model_pending(skip);
    e.stall = (u1 && r1 != 0 && sp[r1]) || (u2 && r2 != 0 && sp[r2]);
    exp_q.push_back(e);

    if (in_rst) begin
      m_rd.delete();
      m_we.delete();
      m_err = 1'b0;
    end else begin
      do_push = iv && (m_rd.size() < DEPTH) && !fl;
      if (wb) begin
        if (m_rd.size() > 0) begin
          void'(m_rd.pop_front());
          void'(m_we.pop_front());
        end else begin
          m_err = 1'b1;
        end
      end
      if (fl) begin
        k = (keep > DEPTH) ? DEPTH : keep;
        while (m_rd.size() > k) begin
          void'(m_rd.pop_back());
          void'(m_we.pop_back());
        end
      end else if (do_push) begin
        m_rd.push_back(rd);
        m_we.push_back(we);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic iss(input int rd);
    step(1, 1, rd, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ret();
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    in_rst = 1'b1;
    idle();
    idle();
    rst_n  = 1'b1;
    in_rst = 1'b0;
  endtask

  function automatic int pick_rd();
    return ($urandom % 8 == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
  endfunction

  // Monitor: compare every DUT output against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("pending",   32'(pending_o),       mon_e.pend);
      chk("inflight",  32'(inflight_cnt_o),  32'(mon_e.cnt));
      chk("issue_rdy", 32'(issue_rdy_o),     32'(mon_e.rdy));
      chk("stall",     32'(hazard_stall_o),  32'(mon_e.stall));
      chk("underflow", 32'(err_underflow_o), 32'(mon_e.err));
    end
  end

  initial begin
    rst_n         = 1'b0;
    in_rst        = 1'b1;
    m_err         = 1'b0;
    issue_valid_i = 1'b0;
    issue_we_i    = 1'b0;
    issue_rd_i    = '0;
    rs1_i         = '0;
    rs2_i         = '0;
    rs1_use_i     = 1'b0;
    rs2_use_i     = 1'b0;
    wb_valid_i    = 1'b0;
    flush_i       = 1'b0;
    flush_keep_i  = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Single issue, then RAW hazard on rs1
    iss(5);
    step(0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    // Duplicate rd stays pending until the last writer retires
    iss(5);
    ret();
    step(0, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    ret();
    idle();
    // Fill, then issue+retire while full: issue dropped
    iss(1); iss(2); iss(3); iss(4);
    step(1, 1, 9, 0, 0, 0, 0, 1, 0, 0);
    iss(10);
    // Full, flush keep=1 with retire: only second-oldest survives
    step(0, 0, 0, 3, 1, 10, 1, 1, 1, 1);
    step(0, 0, 0, 3, 1, 4, 1, 0, 0, 0);
    ret();
    // x0 never pending, never stalls; underflow sticky
    step(1, 1, 0, 0, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    ret();
    ret();
    idle();
    idle();
    // WB-cycle stall on rd=7 at head
    iss(7);
    step(0, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    // Flush keep above DEPTH clamps; issue in flush cycle dropped
    iss(6);
    iss(8);
    step(1, 1, 11, 6, 1, 11, 1, 0, 1, 7);
    step(0, 0, 0, 6, 1, 11, 1, 0, 0, 0);
    step(1, 1, 12, 8, 1, 0, 0, 0, 1, 0);
    idle();

    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      step($urandom % 4 != 0, $urandom % 4 != 0, pick_rd(),
           pick_rd(), $urandom % 2 == 0, pick_rd(), $urandom % 2 == 0,
           $urandom % 2 == 0, $urandom % 16 == 0, int'($urandom_range(0, 7)));
    end
    idle();
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
